mcast_channel: RTL and testbench
================================

# mcast_channel

Parametrised tag-matched multicast channel: delivers one GLB data stream to a ROWS×COLS grid of PE targets. Each target has a scan-loaded X/Y ID, and a word goes to every enabled target whose IDs match the word's tags. An input FIFO decouples the GLB. Completion is tracked per target, so a word retires only when every matched target has accepted it, rather than when any one target is ready. Burst boundaries come from an explicit `in_last` flag, not from valid falling edges. One instance serves each of the ifmap, filter and ipsum channels between the GLB and the PE grid.

## Interface
- `ROWS`, default 12: PE rows.
- `COLS`, default 14: PE columns.
- `XID_BITS`, default 5: X ID / X tag width.
- `YID_BITS`, default 4: Y ID / Y tag width.
- `DATA_BITS`, default 32: payload width.
- `FIFO_DEPTH`, default 4: input FIFO entries; must be a power of 2 and ≥ 2.
- `CNT_BITS`, default 16: burst counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous clear of FIFO, served mask and counters.
- `set_xid` in 1: shift the X ID chain.
- `xid_scan_in` in XID_BITS: X ID entering slot ROWS*COLS-1.
- `set_yid` in 1: shift the Y ID chain.
- `yid_scan_in` in YID_BITS: Y ID entering slot ROWS-1.
- `tgt_en` in ROWS*COLS: per-target enable; bit k is target (k/COLS, k%COLS).
- `in_valid` in 1: GLB word valid.
- `in_ready` out 1: equals ~full.
- `in_data` in DATA_BITS: payload.
- `in_tag_x` in XID_BITS: destination X tag.
- `in_tag_y` in YID_BITS: destination Y tag.
- `in_last` in 1: last word of the burst.
- `tgt_valid` out ROWS*COLS: per-target valid.
- `tgt_ready` in ROWS*COLS: per-target ready.
- `tgt_data` out DATA_BITS: head payload, broadcast to all targets.
- `burst_done` out 1: one-cycle pulse after the last word of a burst retires.
- `burst_len` out CNT_BITS: matched words in the burst just completed.
- `err_nomatch` out 1: one-cycle pulse when a word matching no target is dropped.

## Operation
- **ID chains**
  - X chain has ROWS*COLS slots; Y chain has ROWS slots.
  - On `set_xid`, slot i ← slot i+1 and the top slot ← `xid_scan_in`. The Y chain behaves the same on `set_yid`.
  - After N shifts, the first value shifted in sits in slot (N_slots − N).
  - The chains hold their values through `flush`; only `rst` zeroes them.
- **FIFO**
  - Each entry holds {data, tag_x, tag_y, last}.
  - Push when `in_valid & in_ready`; push and pop may occur in the same cycle.
  - There is no write-through: a word becomes visible at the head one cycle after it is pushed.
- **Match vector**, for the head entry: M[k] = head_valid & tgt_en[k] & (xid[k]==tag_x) & (yid[k/COLS]==tag_y).
- **Served mask** (S, ROWS*COLS bits)
  - `tgt_valid[k]` = M[k] & ~S[k].
  - A handshake on target k sets S[k].
  - pending = M & ~S & ~tgt_ready.
  - The head pops when head_valid and pending==0, i.e. every outstanding target accepts this cycle or has already accepted.
  - On pop, S ← 0. Otherwise S ← S | (tgt_valid & tgt_ready).
- **No-match**: if head_valid and M==0, the head pops that cycle, `err_nomatch` pulses the next cycle, and the word is not counted.
- **Counting**
  - Each matched pop increments `cnt`.
  - A matched pop with last=1 sets `burst_len` ← cnt+1 and `cnt` ← 0, and pulses `burst_done` the next cycle.
  - A no-match pop with last=1 also ends the burst: `burst_len` ← cnt (may be 0), `burst_done` pulses.
  - `cnt` wraps modulo 2^CNT_BITS.
- **Flush**
  - Empties the FIFO and sets S, `cnt`, `burst_done` and `err_nomatch` to 0.
  - `burst_len` holds its value.
  - A push in the same cycle as `flush` is discarded.
- **Mid-transfer changes**: changes to `tgt_en` or the ID chains while the head is pending take effect combinationally on M. Bits of S for targets that are no longer matched are ignored.

## Timing
- Reset values:
  - `tgt_valid`=0, `burst_done`=0, `err_nomatch`=0, `burst_len`=0.
  - `in_ready`=1 (FIFO empty).
  - All IDs 0, S=0, `cnt`=0.
- Reset asserted mid-burst drops every entry immediately, with no `burst_done`.
- Latency:
  - `in_valid` accepted at cycle t → `tgt_valid` at t+1 (FIFO was empty).
  - If all matched targets are ready, the word pops at t+1.
  - Throughput is 1 word/cycle when all matched targets stay ready.
- `burst_done` and `err_nomatch` are registered; each is high for exactly one cycle.
- When the FIFO is full, `in_ready`=0 even if a pop occurs that cycle.
- All outputs except `burst_done`, `err_nomatch` and `burst_len` are combinational from state and inputs. `tgt_ready` must not depend combinationally on `tgt_valid` of another target.

## Test plan
- **Scan and unicast** (ROWS=3, COLS=4)
  - Scan X IDs 0..11 and Y IDs 0,1,2 with all targets enabled.
  - Send 1 word (tag_x=5, tag_y=1, data=0xA5, last=1).
  - Required: only `tgt_valid[5]` rises, at t+1. `burst_done` pulses at t+2 with `burst_len`=1.
- **Multicast with staggered ready**
  - Set all X IDs=0 and send tag (0,0) to row 0.
  - Hold `tgt_ready`[3:0] = 0001, then 0110, then 1000 on successive cycles.
  - Required: `tgt_valid` shrinks 1111→1110→1000→0000; pop occurs in the third cycle, not earlier.
- **No-match drop**
  - Send tag_y=7 followed by a valid word.
  - Required: `err_nomatch` pulses once and no `tgt_valid` rises. The next word is delivered with no stall; `cnt` is unaffected.
- **Backpressure and full**
  - With FIFO_DEPTH=4 and all `tgt_ready`=0, stream 6 words.
  - Required: `in_ready` drops after the 4th push. On release, the 6 words arrive in order and `burst_len`=6.
- **Flush and reset mid-burst**
  - Flush after 2 of 5 words: FIFO empties, no `burst_done`; a new burst of 3 reports `burst_len`=3.
  - Async `rst` mid-burst: all outputs return to their reset values within the same cycle.
- **Enable masking**
  - `tgt_en[5]`=0 with the same tags as the unicast case.
  - Required: word dropped and `err_nomatch` pulses.

Source files
------------

// File: rtl/mcast_channel.sv
// mcast_channel: tag-matched GLB->PE multicast; ID scan chains, input FIFO (in_*), per-target handshakes (tgt_*), burst/no-match status
module mcast_channel #(
  parameter int ROWS       = 12,
  parameter int COLS       = 14,
  parameter int XID_BITS   = 5,
  parameter int YID_BITS   = 4,
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      set_xid,
  input  logic [XID_BITS-1:0]       xid_scan_in,
  input  logic                      set_yid,
  input  logic [YID_BITS-1:0]       yid_scan_in,
  input  logic [ROWS*COLS-1:0]      tgt_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BITS-1:0]      in_data,
  input  logic [XID_BITS-1:0]       in_tag_x,
  input  logic [YID_BITS-1:0]       in_tag_y,
  input  logic                      in_last,
  output logic [ROWS*COLS-1:0]      tgt_valid,
  input  logic [ROWS*COLS-1:0]      tgt_ready,
  output logic [DATA_BITS-1:0]      tgt_data,
  output logic                      burst_done,
  output logic [CNT_BITS-1:0]       burst_len,
  output logic                      err_nomatch
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + XID_BITS + YID_BITS + 1;
  logic [N-1:0][XID_BITS-1:0]    xid;
  logic [ROWS-1:0][YID_BITS-1:0] yid;
  logic [EW-1:0]                 mem [FIFO_DEPTH];
  logic [AW:0]                   wp, rp;
  logic [N-1:0]                  served, match, pending;
  logic [CNT_BITS-1:0]           cnt;
  logic [XID_BITS-1:0]           head_x;
  logic [YID_BITS-1:0]           head_y;
  logic                          head_valid, head_last, full, push, pop, hit;
  assign head_valid = wp != rp;
  assign full       = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign in_ready   = ~full;
  assign push       = in_valid & ~full & ~flush;
  assign {tgt_data, head_x, head_y, head_last} = mem[rp[AW-1:0]];
  for (genvar k = 0; k < N; k++) begin : g_match
    assign match[k] = head_valid & tgt_en[k] & (xid[k] == head_x) & (yid[k/COLS] == head_y);
  end
  assign tgt_valid = match & ~served;
  assign pending   = tgt_valid & ~tgt_ready;
  assign pop       = head_valid & ~|pending;
  assign hit       = |match;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xid <= '0;
      yid <= '0;
    end else begin
      if (set_xid) xid <= {xid_scan_in, xid[N-1:1]};
      if (set_yid) yid <= {yid_scan_in, yid[ROWS-1:1]};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      served      <= '0;
      cnt         <= '0;
      burst_len   <= '0;
      burst_done  <= 1'b0;
      err_nomatch <= 1'b0;
    end else if (flush) begin
      wp          <= '0;
      rp          <= '0;
      served      <= '0;
      cnt         <= '0;
      burst_done  <= 1'b0;
      err_nomatch <= 1'b0;
    end else begin
      wp          <= wp + (AW+1)'(push);
      rp          <= rp + (AW+1)'(pop);
      served      <= pop ? '0 : served | (tgt_valid & tgt_ready);
      burst_done  <= pop & head_last;
      err_nomatch <= pop & ~hit;
      if (pop & head_last) begin
        burst_len <= cnt + CNT_BITS'(hit);
        cnt       <= '0;
      end else if (pop & hit) cnt <= cnt + CNT_BITS'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {in_data, in_tag_x, in_tag_y, in_last};
endmodule

// File: tb/tb_mcast_channel.sv
// tb_mcast_channel: queue-based reference model with per-cycle compare plus directed literal checks
module tb_mcast_channel;
  localparam int R = 3, C = 4, N = 12, XB = 5, YB = 4, DB = 32, D = 4, CB = 16;
  logic clk = 0, rst = 1, flush = 0, set_xid = 0, set_yid = 0;
  logic [XB-1:0] xid_scan_in = '0;
  logic [YB-1:0] yid_scan_in = '0;
  logic [N-1:0]  tgt_en = '1, tgt_ready = '0;
  logic [N-1:0]  tgt_valid;
  logic          in_valid = 0, in_last = 0, in_ready;
  logic [DB-1:0] in_data = '0, tgt_data;
  logic [XB-1:0] in_tag_x = '0;
  logic [YB-1:0] in_tag_y = '0;
  logic          burst_done, err_nomatch;
  logic [CB-1:0] burst_len;
  int tests = 0, fails = 0;

  mcast_channel #(.ROWS(R), .COLS(C), .XID_BITS(XB), .YID_BITS(YB), .DATA_BITS(DB),
                  .FIFO_DEPTH(D), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .set_xid(set_xid), .xid_scan_in(xid_scan_in),
    .set_yid(set_yid), .yid_scan_in(yid_scan_in), .tgt_en(tgt_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_tag_x(in_tag_x), .in_tag_y(in_tag_y),
    .in_last(in_last), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .burst_done(burst_done), .burst_len(burst_len), .err_nomatch(err_nomatch));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [DB-1:0] d; logic [XB-1:0] tx; logic [YB-1:0] ty; logic l;} word_t;
  word_t         q[$];
  logic [XB-1:0] xm[N];
  logic [YB-1:0] ym[R];
  logic [N-1:0]  sv = '0;
  logic [CB-1:0] mcnt = '0, mlen = '0;
  bit            mdone = 0, menm = 0;

  function automatic logic [N-1:0] mmatch();
    logic [N-1:0] m = '0;
    if (q.size() > 0)
      for (int k = 0; k < N; k++)
        m[k] = tgt_en[k] && xm[k] == q[0].tx && ym[k/C] == q[0].ty;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] m;
    bit pop, was_full;
    if (rst) begin
      q.delete();
      sv = '0; mcnt = '0; mlen = '0; mdone = 0; menm = 0;
      for (int i = 0; i < N; i++) xm[i] = '0;
      for (int i = 0; i < R; i++) ym[i] = '0;
    end else begin
      m = mmatch();
      was_full = q.size() == D;
      pop = q.size() > 0 && (m & ~sv & ~tgt_ready) == '0;
      if (set_xid) begin
        for (int i = 0; i < N-1; i++) xm[i] = xm[i+1];
        xm[N-1] = xid_scan_in;
      end
      if (set_yid) begin
        for (int i = 0; i < R-1; i++) ym[i] = ym[i+1];
        ym[R-1] = yid_scan_in;
      end
      if (flush) begin
        q.delete();
        sv = '0; mcnt = '0; mdone = 0; menm = 0;
      end else begin
        mdone = pop && q[0].l;
        menm  = pop && m == '0;
        if (pop) begin
          if (m != '0) mcnt = mcnt + 1;
          if (q[0].l) begin mlen = mcnt; mcnt = '0; end
          void'(q.pop_front());
          sv = '0;
        end else sv = sv | (m & tgt_ready);
        if (in_valid && !was_full) q.push_back('{in_data, in_tag_x, in_tag_y, in_last});
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] m;
    m = mmatch();
    chk("in_ready", in_ready, q.size() < D);
    chk("tgt_valid", tgt_valid, m & ~sv);
    if (q.size() > 0) chk("tgt_data", tgt_data, q[0].d);
    chk("burst_done", burst_done, mdone);
    chk("err_nomatch", err_nomatch, menm);
    chk("burst_len", burst_len, mlen);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic scan(input bit ramp);
    for (int i = 0; i < N; i++) begin
      set_xid = 1; xid_scan_in = ramp ? XB'(i) : '0;
      set_yid = i < R; yid_scan_in = YB'(i);
      step();
    end
    set_xid = 0; set_yid = 0;
  endtask

  task automatic put(input logic [DB-1:0] d, input logic [XB-1:0] x, input logic [YB-1:0] y, input bit l);
    in_valid = 1; in_data = d; in_tag_x = x; in_tag_y = y; in_last = l;
  endtask

  task automatic wait_done(input string nm, input logic [CB-1:0] len);
    for (int i = 0; i < 30 && !burst_done; i++) step();
    chk({nm, "_done"}, burst_done, 1);
    chk({nm, "_len"}, burst_len, len);
  endtask

  initial begin
    step();
    chk("rst_tgt_valid", tgt_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_burst_len", burst_len, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_err_nomatch", err_nomatch, 0);
    rst = 0;
    step();
    scan(1);
    tgt_ready = '1;
    put(32'hA5, 5, 1, 1);
    step();
    in_valid = 0;
    chk("uni_valid", tgt_valid, 12'h020);
    chk("uni_data", tgt_data, 32'hA5);
    step();
    chk("uni_done", burst_done, 1);
    chk("uni_len", burst_len, 1);
    chk("uni_valid_after", tgt_valid, 0);
    tgt_ready = '0;
    scan(0);
    put(32'hB6, 0, 0, 1);
    step();
    in_valid = 0;
    tgt_ready = 12'h001;
    chk("mc_valid0", tgt_valid, 12'h00F);
    step();
    tgt_ready = 12'h006;
    chk("mc_valid1", tgt_valid, 12'h00E);
    step();
    tgt_ready = 12'h008;
    chk("mc_valid2", tgt_valid, 12'h008);
    chk("mc_not_done", burst_done, 0);
    step();
    chk("mc_valid3", tgt_valid, 0);
    chk("mc_done", burst_done, 1);
    tgt_ready = '1;
    put(32'hC7, 0, 7, 0);
    step();
    put(32'h11, 0, 0, 1);
    chk("nm_no_valid", tgt_valid, 0);
    step();
    in_valid = 0;
    chk("nm_err", err_nomatch, 1);
    chk("nm_next_valid", tgt_valid, 12'h00F);
    step();
    chk("nm_err_once", err_nomatch, 0);
    chk("nm_done", burst_done, 1);
    chk("nm_len", burst_len, 1);
    tgt_ready = '0;
    for (int i = 0; i < 6; i++) begin
      put(32'h100 + i, 0, 0, i == 5);
      if (i == 4) begin
        chk("bp_full_in_ready", in_ready, 0);
        tgt_ready = '1;
      end
      for (int w = 0; w < 10 && !in_ready; w++) step();
      step();
    end
    in_valid = 0;
    wait_done("bp", 6);
    tgt_ready = '0;
    put(32'h200, 0, 0, 0);
    step();
    put(32'h201, 0, 0, 0);
    step();
    put(32'h202, 0, 0, 0);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("fl_in_ready", in_ready, 1);
    chk("fl_tgt_valid", tgt_valid, 0);
    chk("fl_len_hold", burst_len, 6);
    step();
    chk("fl_no_done", burst_done, 0);
    tgt_ready = '1;
    for (int i = 0; i < 3; i++) begin
      put(32'h300 + i, 0, 0, i == 2);
      step();
    end
    in_valid = 0;
    wait_done("fl", 3);
    tgt_ready = '0;
    put(32'h400, 0, 0, 0);
    step();
    put(32'h401, 0, 0, 1);
    step();
    in_valid = 0;
    chk("ar_pre_valid", tgt_valid, 12'h00F);
    #2 rst = 1;
    #1;
    chk("ar_tgt_valid", tgt_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_burst_len", burst_len, 0);
    chk("ar_burst_done", burst_done, 0);
    step();
    rst = 0;
    tgt_ready = '1;
    step();
    step();
    chk("ar_no_done", burst_done, 0);
    scan(1);
    tgt_en = '1;
    tgt_en[5] = 0;
    put(32'hA5, 5, 1, 1);
    step();
    in_valid = 0;
    chk("en_no_valid", tgt_valid, 0);
    step();
    chk("en_err", err_nomatch, 1);
    chk("en_done", burst_done, 1);
    chk("en_len", burst_len, 0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
